// File: rtl/memio_bus.sv
// Memory-mapped I/O mapper: region decode for dmem/smem, peripheral registers and keyboard FIFO.
// Optional game tick timer is built only when MEMIO_TIMER_EN is defined.
module memio_bus #(
  parameter int KBD_DEPTH = 8,
  parameter int NLED      = 16,
  parameter int TIMER_DIV = 100000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_writedata,
  input  logic            cpu_wr,
  input  logic            cpu_rd,
  output logic [31:0]     cpu_readdata,
  output logic            dmem_wr,
  input  logic [31:0]     dmem_readdata,
  output logic            smem_wr,
  input  logic [3:0]      smem_readdata,
  input  logic [7:0]      keyb_data,
  input  logic            keyb_valid,
  input  logic [8:0]      accelX,
  input  logic [8:0]      accelY,
  output logic            audEn,
  output logic [31:0]     period,
  output logic [NLED-1:0] LED
);

  localparam int AW = $clog2(KBD_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_DMEM = 2'b01;
  localparam logic [1:0] REG_SMEM = 2'b10;
  localparam logic [1:0] REG_IO   = 2'b11;

  localparam logic [2:0] SEL_KBD    = 3'b000;
  localparam logic [2:0] SEL_ACCEL  = 3'b001;
  localparam logic [2:0] SEL_PERIOD = 3'b010;
  localparam logic [2:0] SEL_LED    = 3'b011;
  localparam logic [2:0] SEL_STATUS = 3'b100;
  localparam logic [2:0] SEL_TICK   = 3'b101;
  localparam logic [2:0] SEL_AUDCTL = 3'b110;

  logic [1:0] region;
  logic [2:0] sel;
  logic       io_wr;
  logic       io_rd;

  assign region = cpu_addr[17:16];
  assign sel    = cpu_addr[4:2];
  assign io_wr  = cpu_wr & (region == REG_IO);
  assign io_rd  = cpu_rd & (region == REG_IO);

  assign dmem_wr = cpu_wr & (region == REG_DMEM) & ~reset;
  assign smem_wr = cpu_wr & (region == REG_SMEM) & ~reset;

  // Address bits outside the decoded fields are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{cpu_addr[31:18], cpu_addr[15:5], cpu_addr[1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      LED    <= '0;
      period <= '0;
      audEn  <= 1'b0;
    end else if (io_wr) begin
      case (sel)
        SEL_PERIOD: period <= cpu_writedata;
        SEL_LED:    LED    <= cpu_writedata[NLED-1:0];
        SEL_AUDCTL: audEn  <= cpu_writedata[0];
        default:    ;
      endcase
    end
  end

  logic [7:0]    kbd_mem [KBD_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;

  assign empty = (count == '0);
  assign full  = (count == CW'(KBD_DEPTH));
  assign pop   = io_rd & (sel == SEL_KBD) & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push  = keyb_valid & (~full | pop);

  always_ff @(posedge clock) begin
    if (push) kbd_mem[wptr] <= keyb_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (keyb_valid && !push)
        overflow <= 1'b1;
      else if (io_wr && sel == SEL_STATUS && cpu_writedata[1])
        overflow <= 1'b0;
    end
  end

  logic [31:0] tick_rd;

`ifdef MEMIO_TIMER_EN
  logic [31:0] presc;
  logic [31:0] tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      tick  <= '0;
    end else if (io_wr && sel == SEL_TICK) begin
      presc <= '0;
      tick  <= cpu_writedata;
    end else if (presc == 32'(TIMER_DIV - 1)) begin
      presc <= '0;
      tick  <= tick + 32'd1;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  assign tick_rd = tick;
`else
  assign tick_rd = '0;
`endif

  logic [31:0] count32;
  logic [31:0] kbd_rd;

  assign count32 = 32'(count);
  assign kbd_rd  = empty ? 32'd0 : {23'b0, 1'b1, kbd_mem[rptr]};

  always_comb begin
    cpu_readdata = '0;
    case (region)
      REG_DMEM: cpu_readdata = dmem_readdata;
      REG_SMEM: cpu_readdata = {28'b0, smem_readdata};
      REG_IO: begin
        case (sel)
          SEL_KBD:    cpu_readdata = kbd_rd;
          SEL_ACCEL:  cpu_readdata = {7'b0, accelX, 7'b0, accelY};
          SEL_PERIOD: cpu_readdata = period;
          SEL_LED:    cpu_readdata = 32'(LED);
          SEL_STATUS: cpu_readdata = {16'b0, count32[7:0], 6'b0, overflow, empty};
          SEL_TICK:   cpu_readdata = tick_rd;
          SEL_AUDCTL: cpu_readdata = {31'b0, audEn};
          default:    cpu_readdata = '0;
        endcase
      end
      default: cpu_readdata = '0;
    endcase
  end

endmodule
